// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send, then eleven
// device-clocked bit slots driven open-drain through output enables, with ACK capture and a watchdog.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_ok,
    output logic       err
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_REQ       = 3'd2,
        ST_SEND      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } state_t;

    // Odd parity: the frame carries a 1 when the byte holds an even number of ones.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

    state_t           state_r, state_next_s;
    logic [INH_W-1:0] inh_cnt_r, inh_cnt_next_s;
    logic [WD_W-1:0]  wd_r, wd_next_s;
    logic [3:0]       bit_cnt_r, bit_cnt_next_s;
    logic [7:0]       byte_r, byte_next_s;
    logic             parity_r, parity_next_s;
    logic             ack_r, ack_next_s;

    logic clk_meta_r, clk_sync_r, clk_hist_r;
    logic data_meta_r, data_sync_r;
    logic fe_s;

    logic clk_oe_next_s, data_oe_next_s;
    logic done_next_s, ack_ok_next_s, err_next_s;
    logic tx_ready_next_s;

    assign fe_s = clk_hist_r & ~clk_sync_r;

    // Line synchronizers plus the clock history flop used for falling-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_meta_r  <= 1'b1;
            clk_sync_r  <= 1'b1;
            clk_hist_r  <= 1'b1;
            data_meta_r <= 1'b1;
            data_sync_r <= 1'b1;
        end else begin
            clk_meta_r  <= ps2_clk;
            clk_sync_r  <= clk_meta_r;
            clk_hist_r  <= clk_sync_r;
            data_meta_r <= ps2_data;
            data_sync_r <= data_meta_r;
        end
    end

    // Next-state, counter and next-output logic for the request/send sequence.
    always_comb begin
        state_next_s   = state_r;
        inh_cnt_next_s = inh_cnt_r;
        wd_next_s      = wd_r;
        bit_cnt_next_s = bit_cnt_r;
        byte_next_s    = byte_r;
        parity_next_s  = parity_r;
        ack_next_s     = ack_r;
        clk_oe_next_s  = ps2_clk_oe;
        data_oe_next_s = ps2_data_oe;
        done_next_s    = 1'b0;
        ack_ok_next_s  = 1'b0;
        err_next_s     = 1'b0;

        case (state_r)
            ST_IDLE: begin
                clk_oe_next_s  = 1'b0;
                data_oe_next_s = 1'b0;
                if (tx_valid) begin
                    byte_next_s    = tx_data;
                    parity_next_s  = odd_parity(tx_data);
                    inh_cnt_next_s = {INH_W{1'b0}};
                    clk_oe_next_s  = 1'b1;
                    state_next_s   = ST_INHIBIT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end

            ST_INHIBIT: begin
                clk_oe_next_s = 1'b1;
                if (inh_cnt_r == INH_W'(INHIBIT_CYCLES - 1)) begin
                    data_oe_next_s = 1'b1;
                    state_next_s   = ST_REQ;
                end else begin
                    data_oe_next_s = 1'b0;
                    inh_cnt_next_s = inh_cnt_r + INH_W'(1);
                end
            end

            ST_REQ: begin
                // Start bit stays driven low; releasing the clock hands timing to the device.
                clk_oe_next_s  = 1'b0;
                data_oe_next_s = 1'b1;
                bit_cnt_next_s = 4'd0;
                wd_next_s      = {WD_W{1'b0}};
                state_next_s   = ST_SEND;
            end

            ST_SEND: begin
                clk_oe_next_s = 1'b0;
                if (fe_s) begin
                    wd_next_s      = {WD_W{1'b0}};
                    bit_cnt_next_s = bit_cnt_r + 4'd1;
                    case (bit_cnt_r)
                        4'd0, 4'd1, 4'd2, 4'd3,
                        4'd4, 4'd5, 4'd6, 4'd7: data_oe_next_s = ~byte_r[bit_cnt_r[2:0]];
                        4'd8:    data_oe_next_s = ~parity_r;
                        4'd9:    data_oe_next_s = 1'b0;
                        4'd10: begin
                            ack_next_s     = data_sync_r;
                            data_oe_next_s = 1'b0;
                            state_next_s   = ST_WAIT_IDLE;
                        end
                        default: begin
                            data_oe_next_s = 1'b0;
                            state_next_s   = ST_WAIT_IDLE;
                        end
                    endcase
                end else if (wd_r == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    data_oe_next_s = 1'b0;
                    done_next_s    = 1'b1;
                    err_next_s     = 1'b1;
                    state_next_s   = ST_IDLE;
                end else begin
                    wd_next_s = wd_r + WD_W'(1);
                end
            end

            ST_WAIT_IDLE: begin
                clk_oe_next_s  = 1'b0;
                data_oe_next_s = 1'b0;
                if (clk_sync_r && data_sync_r) begin
                    done_next_s   = 1'b1;
                    ack_ok_next_s = ~ack_r;
                    state_next_s  = ST_IDLE;
                end else if (fe_s) begin
                    wd_next_s = {WD_W{1'b0}};
                end else if (wd_r == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    done_next_s  = 1'b1;
                    err_next_s   = 1'b1;
                    state_next_s = ST_IDLE;
                end else begin
                    wd_next_s = wd_r + WD_W'(1);
                end
            end

            default: begin
                clk_oe_next_s  = 1'b0;
                data_oe_next_s = 1'b0;
                state_next_s   = ST_IDLE;
            end
        endcase

        tx_ready_next_s = (state_next_s == ST_IDLE);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            inh_cnt_r   <= {INH_W{1'b0}};
            wd_r        <= {WD_W{1'b0}};
            bit_cnt_r   <= 4'd0;
            byte_r      <= 8'd0;
            parity_r    <= 1'b0;
            ack_r       <= 1'b1;
            tx_ready    <= 1'b1;
            busy        <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            done        <= 1'b0;
            ack_ok      <= 1'b0;
            err         <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            inh_cnt_r   <= inh_cnt_next_s;
            wd_r        <= wd_next_s;
            bit_cnt_r   <= bit_cnt_next_s;
            byte_r      <= byte_next_s;
            parity_r    <= parity_next_s;
            ack_r       <= ack_next_s;
            tx_ready    <= tx_ready_next_s;
            busy        <= ~tx_ready_next_s;
            ps2_clk_oe  <= clk_oe_next_s;
            ps2_data_oe <= data_oe_next_s;
            done        <= done_next_s;
            ack_ok      <= ack_ok_next_s;
            err         <= err_next_s;
        end
    end

endmodule
